// File: rtl/sockit_spi_pkg.sv
// Shared constants and types for the SPI master register block.
// Holds the CPU register address map, status/irq bit positions and the
// command FIFO entry layout used by sockit_spi_regq.
package sockit_spi_pkg;

    // CPU word addresses of the register map
    localparam logic [2:0] ADR_CFG = 3'd0;
    localparam logic [2:0] ADR_PAR = 3'd1;
    localparam logic [2:0] ADR_CTL = 3'd2;
    localparam logic [2:0] ADR_DAT = 3'd3;
    localparam logic [2:0] ADR_IRQ = 3'd4;
    localparam logic [2:0] ADR_DMA = 3'd5;
    localparam logic [2:0] ADR_ROF = 3'd6;
    localparam logic [2:0] ADR_WOF = 3'd7;

    // status register flag positions (levels live in [7:0] and [15:8])
    localparam int STS_CMD_FULL  = 16;
    localparam int STS_CMD_EMPTY = 17;
    localparam int STS_DAT_FULL  = 18;
    localparam int STS_DAT_EMPTY = 19;

    // irq register: status bits at the bottom, enables from bit 16 up
    localparam int IRQ_CMD_EMPTY = 0;
    localparam int IRQ_DAT_AVAIL = 1;
    localparam int IRQ_TSK_RDY   = 2;
    localparam int IRQ_EN_LSB    = 16;

    // one queued SPI command: control word on top of the data word
    typedef struct packed {
        logic [11:0] ctl;
        logic [31:0] dat;
    } cmd_entry_t;

endpackage

// File: rtl/sockit_spi_fifo.sv
// Synchronous show-ahead FIFO: o_data always presents the oldest entry.
// Depth is 2**AW; level counts 0..2**AW so it needs AW+1 bits. Pushes into
// a full FIFO and pops from an empty one are dropped. Storage is not reset,
// only the pointers are.
module sockit_spi_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_level = r_wr - r_rd;
    // level never exceeds DEPTH, so its top bit alone marks full
    assign o_full  = o_level[AW];
    assign o_empty = (r_wr == r_rd);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    // advance read/write pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // write storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sockit_spi_regq.sv
// CPU register block for the SPI master with queued command output and
// queued data input. Optional interrupt register enabled by defining
// SOCKIT_SPI_REGQ_IRQ_EN; without it adr 4 reads 0 and reg_irq stays low.
// Bus handshake: an access is accepted on the cycle it is presented with
// reg_wrq=0; while reg_wrq=1 the CPU holds the access and nothing in the
// block changes for it. Command output pops on cmo_vld&cmo_rdy, data input
// pushes on cmi_vld&cmi_rdy.
module sockit_spi_regq #(
    parameter logic [31:0] CFG_RST = 32'h00000000,
    parameter logic [31:0] CFG_MSK = 32'hffffffff,
    parameter logic [31:0] ADR_ROF = 32'h00000000,
    parameter logic [31:0] ADR_WOF = 32'h00000000,
    parameter int          CCO     = 12,
    parameter int          CCI     = 4,
    parameter int          CDW     = 32,
    parameter int          CFD     = 2,
    parameter int          DFD     = 2,
    parameter int          SSN     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           reg_wen,
    input  logic           reg_ren,
    input  logic [2:0]     reg_adr,
    input  logic [31:0]    reg_wdt,
    output logic [31:0]    reg_rdt,
    output logic           reg_wrq,
    output logic           reg_err,
    output logic           reg_irq,
    output logic [31:0]    spi_cfg,
    output logic [31:0]    adr_rof,
    output logic [31:0]    adr_wof,
    output logic           cmo_vld,
    output logic [CCO-1:0] cmo_ctl,
    output logic [CDW-1:0] cmo_dat,
    input  logic           cmo_rdy,
    input  logic           cmi_vld,
    input  logic [CCI-1:0] cmi_ctl,
    input  logic [CDW-1:0] cmi_dat,
    output logic           cmi_rdy,
    output logic           tsk_vld,
    output logic [31:0]    tsk_ctl,
    input  logic [31:0]    tsk_sts,
    input  logic           tsk_rdy
);

    logic [31:0]        r_cfg, r_rof, r_wof;
    logic [CDW-1:0]     r_dat;
    logic               w_wrq, w_cmd_push, w_cmd_pop, w_dat_push, w_dat_pop;
    logic [CCO-1:0]     w_cmd_ctl;
    logic [CCO+CDW-1:0] w_cmd_head;
    logic               w_cmd_full, w_cmd_empty, w_dat_full, w_dat_empty;
    logic [CFD:0]       w_cmd_lvl;
    logic [DFD:0]       w_dat_lvl;
    logic [CDW-1:0]     w_dat_head;
    logic [31:0]        w_sts, w_par, w_irq_rdt;
    logic               w_irq_feat;
    logic               w_unused;

    // command control field ignored on the input side
    assign w_unused = ^cmi_ctl;

    // wait request: full command queue, empty data queue, or busy DMA engine
    always_comb begin
        w_wrq = 1'b0;
        case (reg_adr)
            sockit_spi_pkg::ADR_CTL: w_wrq = reg_wen & w_cmd_full;
            sockit_spi_pkg::ADR_DAT: w_wrq = reg_ren & w_dat_empty;
            sockit_spi_pkg::ADR_DMA: w_wrq = (reg_wen | reg_ren) & ~tsk_rdy;
            default:                 w_wrq = 1'b0;
        endcase
    end

    assign reg_wrq    = w_wrq;
    assign reg_err    = reg_wen & (reg_adr == sockit_spi_pkg::ADR_PAR);
    assign w_cmd_push = reg_wen & (reg_adr == sockit_spi_pkg::ADR_CTL) & ~w_wrq;
    assign w_cmd_pop  = ~w_cmd_empty & cmo_rdy;
    assign w_dat_push = cmi_vld & ~w_dat_full;
    assign w_dat_pop  = reg_ren & (reg_adr == sockit_spi_pkg::ADR_DAT) & ~w_wrq;
    assign w_cmd_ctl  = CCO'({reg_wdt[12:8], reg_wdt[6:0]});

    assign tsk_vld = reg_wen & (reg_adr == sockit_spi_pkg::ADR_DMA) & ~w_wrq;
    assign tsk_ctl = reg_wdt;

    sockit_spi_fifo #(.DW(CCO + CDW), .AW(CFD)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cmd_push),
        .i_data  ({w_cmd_ctl, r_dat}),
        .i_pop   (w_cmd_pop),
        .o_data  (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty),
        .o_level (w_cmd_lvl)
    );

    sockit_spi_fifo #(.DW(CDW), .AW(DFD)) u_dat_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_dat_push),
        .i_data  (cmi_dat),
        .i_pop   (w_dat_pop),
        .o_data  (w_dat_head),
        .o_full  (w_dat_full),
        .o_empty (w_dat_empty),
        .o_level (w_dat_lvl)
    );

    assign cmo_vld = ~w_cmd_empty;
    assign cmo_ctl = w_cmd_head[CCO+CDW-1:CDW];
    assign cmo_dat = w_cmd_head[CDW-1:0];
    assign cmi_rdy = ~w_dat_full;

    // plain configuration, offset and data-latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= CFG_RST;
            r_rof <= ADR_ROF;
            r_wof <= ADR_WOF;
            r_dat <= '0;
        end else if (reg_wen) begin
            case (reg_adr)
                sockit_spi_pkg::ADR_CFG: r_cfg <= (CFG_RST & ~CFG_MSK) | (reg_wdt & CFG_MSK);
                sockit_spi_pkg::ADR_DAT: r_dat <= reg_wdt[CDW-1:0];
                sockit_spi_pkg::ADR_ROF: r_rof <= reg_wdt;
                sockit_spi_pkg::ADR_WOF: r_wof <= reg_wdt;
                default: ;
            endcase
        end
    end

    assign spi_cfg = r_cfg;
    assign adr_rof = r_rof;
    assign adr_wof = r_wof;

    // status word: queue levels and full/empty flags
    always_comb begin
        w_sts                                = 32'd0;
        w_sts[7:0]                           = 8'(w_cmd_lvl);
        w_sts[15:8]                          = 8'(w_dat_lvl);
        w_sts[sockit_spi_pkg::STS_CMD_FULL]  = w_cmd_full;
        w_sts[sockit_spi_pkg::STS_CMD_EMPTY] = w_cmd_empty;
        w_sts[sockit_spi_pkg::STS_DAT_FULL]  = w_dat_full;
        w_sts[sockit_spi_pkg::STS_DAT_EMPTY] = w_dat_empty;
    end

    assign w_par = {22'd0, w_irq_feat, 3'(DFD), 3'(CFD), 3'(SSN - 1)};

`ifdef SOCKIT_SPI_REGQ_IRQ_EN
    logic [2:0] r_irq_sts, r_irq_en, w_irq_evt, w_irq_clr, w_irq_sts_nxt, w_irq_en_nxt;
    logic       r_irq, r_tsk_rdy_d, w_irq_wr;

    assign w_irq_feat = 1'b1;
    assign w_irq_wr   = reg_wen & (reg_adr == sockit_spi_pkg::ADR_IRQ);

    // interrupt sources; new events win over a same-cycle clear
    always_comb begin
        w_irq_evt = 3'd0;
        w_irq_evt[sockit_spi_pkg::IRQ_CMD_EMPTY] = w_cmd_pop & ~w_cmd_push &
                                                   (w_cmd_lvl == {{CFD{1'b0}}, 1'b1});
        w_irq_evt[sockit_spi_pkg::IRQ_DAT_AVAIL] = w_dat_push & w_dat_empty;
        w_irq_evt[sockit_spi_pkg::IRQ_TSK_RDY]   = tsk_rdy & ~r_tsk_rdy_d;
        w_irq_clr     = w_irq_wr ? reg_wdt[2:0] : 3'd0;
        w_irq_sts_nxt = (r_irq_sts & ~w_irq_clr) | w_irq_evt;
        w_irq_en_nxt  = w_irq_wr ? reg_wdt[sockit_spi_pkg::IRQ_EN_LSB +: 3] : r_irq_en;
    end

    // irq status/enable and the registered request line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_sts <= 3'd0;
            r_irq_en  <= 3'd0;
            r_irq     <= 1'b0;
        end else begin
            r_irq_sts <= w_irq_sts_nxt;
            r_irq_en  <= w_irq_en_nxt;
            r_irq     <= |(w_irq_sts_nxt & w_irq_en_nxt);
        end
    end

    // tsk_rdy history tracks the pin through reset so no false edge follows it
    always_ff @(posedge clk) begin
        r_tsk_rdy_d <= tsk_rdy;
    end

    assign reg_irq   = r_irq;
    assign w_irq_rdt = {13'd0, r_irq_en, 13'd0, r_irq_sts};
`else
    assign w_irq_feat = 1'b0;
    assign reg_irq    = 1'b0;
    assign w_irq_rdt  = 32'd0;
`endif

    // combinational read mux
    always_comb begin
        reg_rdt = 32'd0;
        case (reg_adr)
            sockit_spi_pkg::ADR_CFG: reg_rdt = r_cfg;
            sockit_spi_pkg::ADR_PAR: reg_rdt = w_par;
            sockit_spi_pkg::ADR_CTL: reg_rdt = w_sts;
            sockit_spi_pkg::ADR_DAT: reg_rdt = 32'(w_dat_head);
            sockit_spi_pkg::ADR_IRQ: reg_rdt = w_irq_rdt;
            sockit_spi_pkg::ADR_DMA: reg_rdt = tsk_sts;
            sockit_spi_pkg::ADR_ROF: reg_rdt = r_rof;
            sockit_spi_pkg::ADR_WOF: reg_rdt = r_wof;
            default:                 reg_rdt = 32'd0;
        endcase
    end

endmodule
